mdu_hilo: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX beside the single-cycle ALU.
- Executes mult/multu/div/divu with a configurable fixed latency and mthi/mtlo in a single cycle.
- Exposes `busy` so the hazard unit stalls mfhi/mflo and further MD ops; `flush` cancels an in-flight op on an exception.

---
 rtl/mdu_hilo_pkg.sv | 40 ++++
 rtl/mdu_arith.sv | 101 ++++++++++
 rtl/mdu_hilo.sv | 101 ++++++++++
 tb/tb_mdu_hilo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared opcodes, FSM state type and opcode helpers for the HI/LO multiply/divide unit.
// The multiply-accumulate opcodes are only treated as live when MDU_MADD_EN is defined.
package mdu_hilo_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdState_t;

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for a fixed multi-cycle latency.
  function automatic logic isLongOp(input logic [3:0] op);
    logic result;
    result = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: result = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: result = 1'b1;
`endif
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational signed/unsigned multiply and divide producing the next HI/LO pair.
// With MDU_MADD_EN defined it also accumulates the product onto the current HI/LO.
module mdu_arith
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
`ifdef MDU_MADD_EN
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
`endif
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_wrEn
);

  logic [2*WIDTH-1:0] w_prodS;
  logic [2*WIDTH-1:0] w_prodU;
  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_safeB;
  logic [WIDTH-1:0]   w_safeMagB;
  logic [WIDTH-1:0]   w_qU;
  logic [WIDTH-1:0]   w_rU;
  logic [WIDTH-1:0]   w_qMag;
  logic [WIDTH-1:0]   w_rMag;
  logic [WIDTH-1:0]   w_qS;
  logic [WIDTH-1:0]   w_rS;
  logic               w_divZero;

  // Truncating a product of sign-extended operands to 2*WIDTH gives the exact signed product.
  assign w_prodU = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign w_prodS = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};

  assign w_signA    = i_a[WIDTH-1];
  assign w_signB    = i_b[WIDTH-1];
  assign w_magA     = w_signA ? (~i_a + 1'b1) : i_a;
  assign w_magB     = w_signB ? (~i_b + 1'b1) : i_b;
  assign w_divZero  = (i_b == '0);
  assign w_safeB    = w_divZero ? {{(WIDTH-1){1'b0}}, 1'b1} : i_b;
  assign w_safeMagB = w_divZero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_magB;

  assign w_qU   = i_a / w_safeB;
  assign w_rU   = i_a % w_safeB;
  assign w_qMag = w_magA / w_safeMagB;
  assign w_rMag = w_magA % w_safeMagB;
  // MIN/-1 falls out naturally: |MIN| = 2^(W-1), negated back to MIN with remainder 0.
  assign w_qS   = (w_signA ^ w_signB) ? (~w_qMag + 1'b1) : w_qMag;
  assign w_rS   = w_signA ? (~w_rMag + 1'b1) : w_rMag;

  always_comb begin
    o_hi   = '0;
    o_lo   = '0;
    o_wrEn = 1'b0;
    case (i_op)
      MD_MULT: begin
        {o_hi, o_lo} = w_prodS;
        o_wrEn       = 1'b1;
      end
      MD_MULTU: begin
        {o_hi, o_lo} = w_prodU;
        o_wrEn       = 1'b1;
      end
      MD_DIV: begin
        o_lo   = w_qS;
        o_hi   = w_rS;
        o_wrEn = !w_divZero;
      end
      MD_DIVU: begin
        o_lo   = w_qU;
        o_hi   = w_rU;
        o_wrEn = !w_divZero;
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {o_hi, o_lo} = {i_hi, i_lo} + w_prodS;
        o_wrEn       = 1'b1;
      end
      MD_MADDU: begin
        {o_hi, o_lo} = {i_hi, i_lo} + w_prodU;
        o_wrEn       = 1'b1;
      end
      MD_MSUB: begin
        {o_hi, o_lo} = {i_hi, i_lo} - w_prodS;
        o_wrEn       = 1'b1;
      end
      MD_MSUBU: begin
        {o_hi, o_lo} = {i_hi, i_lo} - w_prodU;
        o_wrEn       = 1'b1;
      end
`endif
      default: o_wrEn = 1'b0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  mdState_t         r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_hiNext;
  logic [WIDTH-1:0] w_loNext;
  logic             w_wrEn;

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_op   (r_op),
`ifdef MDU_MADD_EN
    .i_hi   (r_hi),
    .i_lo   (r_lo),
`endif
    .o_hi   (w_hiNext),
    .o_lo   (w_loNext),
    .o_wrEn (w_wrEn)
  );

  // Operands are captured at issue so the arithmetic sees stable inputs for the whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MD_NONE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            if (isLongOp(mdOp)) begin
              r_a     <= A;
              r_b     <= B;
              r_op    <= mdOp;
              r_cnt   <= isDivOp(mdOp) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
              r_state <= S_RUN;
            end else if (mdOp == MD_MTHI) begin
              r_hi <= A;
            end else if (mdOp == MD_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            if (w_wrEn) begin
              r_hi <= w_hiNext;
              r_lo <= w_loNext;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed plan cases plus randomized ops against an
// arithmetic reference model of HI/LO (MDU_MADD_EN adds the accumulate cases).
module tb_mdu_hilo;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   mdOp;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         flush;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int compared;
  int mismatched;

  logic [W-1:0] mHi;
  logic [W-1:0] mLo;

  mdu_hilo #(
    .WIDTH   (W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdOp  (mdOp),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".hi"}, hi, mHi);
    checkVal({tag, ".lo"}, lo, mLo);
  endtask

  // Reference model: what HI/LO become and how long the unit is busy.
  task automatic modelOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
    longint sa, sb, q, r;
    logic [2*W-1:0] sp, up, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = 64'(sa * sb);
    up  = {32'b0, a} * {32'b0, b};
    acc = {mHi, mLo};
    lat = 0;
    case (op)
      4'd1: begin {mHi, mLo} = sp; lat = MUL_LAT; end
      4'd2: begin {mHi, mLo} = up; lat = MUL_LAT; end
      4'd3: begin
        lat = DIV_LAT;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          mLo = q[W-1:0];
          mHi = r[W-1:0];
        end
      end
      4'd4: begin
        lat = DIV_LAT;
        if (b != 0) begin
          mLo = a / b;
          mHi = a % b;
        end
      end
      4'd5: mHi = a;
      4'd6: mLo = a;
`ifdef MDU_MADD_EN
      4'd7:  begin {mHi, mLo} = acc + sp; lat = MUL_LAT; end
      4'd8:  begin {mHi, mLo} = acc + up; lat = MUL_LAT; end
      4'd9:  begin {mHi, mLo} = acc - sp; lat = MUL_LAT; end
      4'd10: begin {mHi, mLo} = acc - up; lat = MUL_LAT; end
`endif
      default: lat = 0;
    endcase
  endtask

  // Issue one op, scramble the operand inputs afterwards, count busy cycles, then check HI/LO.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag);
    int lat;
    int busyCnt;
    @(negedge clk);
    start = 1'b1;
    mdOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    mdOp  = 4'd0;
    A     = $urandom;
    B     = $urandom;
    modelOp(op, a, b, lat);
    busyCnt = 0;
    while (busy && busyCnt < 100) begin
      busyCnt++;
      @(negedge clk);
    end
    checkVal({tag, ".busyCycles"}, W'(busyCnt), W'(lat));
    checkOutput(tag);
  endtask

  // Issue a long op then flush during its k-th busy cycle; nothing may commit.
  task automatic flushAt(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int k, input string tag);
    @(negedge clk);
    start = 1'b1;
    mdOp  = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    mdOp  = 4'd0;
    repeat (k - 1) @(negedge clk);
    checkVal({tag, ".busyBeforeFlush"}, W'(busy), W'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkVal({tag, ".busyAfterFlush"}, W'(busy), W'(0));
    repeat (DIV_LAT) @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    int lat;
    logic [3:0]   rOp;
    logic [W-1:0] rA, rB;

    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    start = 1'b0;
    mdOp  = 4'd0;
    A     = '0;
    B     = '0;
    flush = 1'b0;
    mHi   = '0;
    mLo   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkVal("reset.busy", W'(busy), W'(0));
    checkOutput("reset");

    applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, "mult");
    checkVal("mult.hiConst", hi, 32'hFFFFFFFF);
    checkVal("mult.loConst", lo, 32'hFFFFFFFA);

    applyStimulus(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    checkVal("multu.hiConst", hi, 32'hFFFFFFFE);
    checkVal("multu.loConst", lo, 32'h00000001);

    applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, "div");
    checkVal("div.loConst", lo, 32'hFFFFFFFD);
    checkVal("div.hiConst", hi, 32'hFFFFFFFF);

    applyStimulus(4'd4, 32'hFFFFFFF9, 32'd2, "divu");
    checkVal("divu.loConst", lo, 32'h7FFFFFFC);
    checkVal("divu.hiConst", hi, 32'h00000001);

    applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, "divMinNeg1");
    checkVal("divMinNeg1.loConst", lo, 32'h80000000);
    checkVal("divMinNeg1.hiConst", hi, 32'h00000000);

    applyStimulus(4'd5, 32'h11, 32'h0, "mthi");
    applyStimulus(4'd6, 32'h22, 32'h0, "mtlo");
    applyStimulus(4'd3, 32'h1234, 32'h0, "divByZero");
    checkVal("divByZero.hiConst", hi, 32'h11);
    checkVal("divByZero.loConst", lo, 32'h22);

    flushAt(4'd3, 32'd100, 32'd7, 4, "flushMid");
    flushAt(4'd3, 32'd100, 32'd7, DIV_LAT, "flushLast");
    flushAt(4'd1, 32'd9, 32'd9, MUL_LAT, "flushLastMul");

    // A flush in the issue cycle cancels the start, even for single-cycle moves.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mdOp = 4'd6; A = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; mdOp = 4'd0;
    checkOutput("flushWithMtlo");
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mdOp = 4'd1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; mdOp = 4'd0;
    checkVal("flushWithMult.busy", W'(busy), W'(0));

    // A start while busy is dropped; the divide result alone lands.
    @(negedge clk);
    start = 1'b1; mdOp = 4'd4; A = 32'd50; B = 32'd8;
    @(negedge clk);
    mdOp = 4'd6; A = 32'h55;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0;
    modelOp(4'd4, 32'd50, 32'd8, lat);
    repeat (DIV_LAT) @(negedge clk);
    checkVal("startWhileBusy.busy", W'(busy), W'(0));
    checkOutput("startWhileBusy");
    applyStimulus(4'd6, 32'h55, 32'h0, "mtloIdle");
    checkVal("mtloIdle.loConst", lo, 32'h55);

    applyStimulus(4'd0, 32'h77, 32'h77, "opNone");
    applyStimulus(4'd13, 32'h77, 32'h77, "opUnknown");

`ifdef MDU_MADD_EN
    applyStimulus(4'd5, 32'h0, 32'h0, "maddSetHi");
    applyStimulus(4'd6, 32'h1, 32'h0, "maddSetLo");
    applyStimulus(4'd7, 32'd2, 32'd3, "madd");
    checkVal("madd.loConst", lo, 32'd7);
`endif

    // Reset in the middle of a multiply aborts it and clears HI/LO.
    applyStimulus(4'd5, 32'hABCD, 32'h0, "preResetHi");
    @(negedge clk);
    start = 1'b1; mdOp = 4'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mHi = '0;
    mLo = '0;
    checkVal("resetMid.busy", W'(busy), W'(0));
    checkOutput("resetMid");
    repeat (MUL_LAT) @(negedge clk);
    checkOutput("resetMidLater");

    for (int i = 0; i < 40; i++) begin
      rOp = 4'($urandom_range(0, 15));
      rA  = $urandom;
      rB  = $urandom;
      case ($urandom_range(0, 7))
        0: rB = '0;
        1: begin rA = 32'h80000000; rB = 32'hFFFFFFFF; end
        2: rB = 32'($urandom_range(1, 9));
        default: ;
      endcase
      applyStimulus(rOp, rA, rB, $sformatf("rand%0d_op%0d", i, rOp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
